// File: rtl/wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_burst_master_pkg
// Purpose : Shared constants and FSM state encoding for wb_burst_master.
//           MAX_BURST     - longest burst in words (i_cmd_len + 1)
//           RD_FIFO_DEPTH - read-data buffer depth; one full burst fits
//           CNT_W         - issued/acked counter width, counts 0..MAX_BURST
//           TMO_W         - timeout counter width, TIMEOUT_CYCLES <= 65535
// Revision: 1.0 - initial release
// ============================================================================
package wb_burst_master_pkg;

    localparam int MAX_BURST     = 16;
    localparam int RD_FIFO_DEPTH = MAX_BURST;
    localparam int CNT_W         = $clog2(MAX_BURST) + 1;
    localparam int TMO_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with valid/ready output. Holds read data
//           returned by the slave until the host drains it.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_push / i_push_data - write side (caller guarantees no overflow)
//           o_valid / i_ready / o_data - standard output handshake
// Notes   : DEPTH must be a power of two (pointers wrap naturally).
//           A word pushed in cycle t is visible on o_data in cycle t+1.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = o_valid && i_ready;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : wb_burst_master
// Purpose : Wishbone pipelined-mode master. Turns a command + write-data
//           stream into single/incrementing bursts of 32-bit WB cycles and
//           buffers read data in a 16-entry FIFO. Hung cycles are aborted
//           after TIMEOUT_CYCLES cycles without progress.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_cmd_*  / o_cmd_ready   - command (we, word addr, len-1, sel)
//           i_wdata* / o_wdata_ready - write-data stream
//           o_rdata* / i_rdata_ready - read-data stream (FIFO output)
//           o_done, o_err            - end-of-burst pulse, err = timeout
//           o_wb_*, i_wb_*           - Wishbone pipelined master port
// Revision: 1.0 - initial release
// ============================================================================
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [3:0]               i_cmd_len,
    input  logic [3:0]               i_cmd_sel,
    input  logic                     i_wdata_valid,
    output logic                     o_wdata_ready,
    input  logic [31:0]              i_wdata,
    output logic                     o_rdata_valid,
    input  logic                     i_rdata_ready,
    output logic [31:0]              o_rdata,
    output logic                     o_done,
    output logic                     o_err,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]              o_wb_data,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic [31:0]              i_wb_data
);

    localparam logic [TMO_W-1:0]         c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]         c_TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0]         c_CNT_ONE  = CNT_W'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] c_ADDR_ONE = WB_ADDR_WIDTH'(1);

    state_t                   r_state;
    logic                     r_cyc;
    logic                     r_stb;
    logic                     r_wb_we;
    logic [WB_ADDR_WIDTH-1:0] r_wb_addr;
    logic [31:0]              r_wb_data;
    logic [3:0]               r_wb_sel;
    logic [3:0]               r_cmd_sel;
    logic [WB_ADDR_WIDTH-1:0] r_next_addr;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         r_issued;
    logic [CNT_W-1:0]         r_acked;
    logic [TMO_W-1:0]         r_tmo;
    logic                     r_done;
    logic                     r_err;

    logic                     w_cmd_ready;
    logic                     w_cmd_fire;
    logic                     w_accept;
    logic                     w_ack;
    logic                     w_progress;
    logic [CNT_W-1:0]         w_acked_nxt;
    logic                     w_burst_ok;
    logic                     w_tmo_hit;
    logic                     w_load;
    logic                     w_load_we;
    logic [WB_ADDR_WIDTH-1:0] w_load_addr;
    logic [3:0]               w_load_sel;
    logic [CNT_W-1:0]         w_issued_base;
    logic                     w_fifo_valid;

    // New commands wait for the read FIFO to drain, so a full-length read
    // burst always fits without overflow checks.
    assign w_cmd_ready = (r_state == ST_IDLE) && !w_fifo_valid;
    assign w_cmd_fire  = i_cmd_valid && w_cmd_ready;
    assign w_accept    = r_stb && !i_wb_stall;
    assign w_ack       = i_wb_ack && r_cyc;
    assign w_progress  = w_accept || w_ack;
    assign w_acked_nxt = r_acked + {{(CNT_W-1){1'b0}}, w_ack};
    assign w_burst_ok  = (r_state == ST_BUS) && (w_acked_nxt == r_count);
    // An ack in the expiry cycle counts as progress, so a last-word ack
    // coinciding with expiry completes the burst cleanly.
    assign w_tmo_hit   = (r_state == ST_BUS) && !w_progress && (r_tmo == c_TMO_LAST);

    // The request register is loaded either straight from the command
    // (first word, so stb rises the cycle after the handshake) or from
    // the running burst state when the previous request has left.
    always_comb begin
        w_load        = 1'b0;
        w_load_we     = r_wb_we;
        w_load_addr   = r_next_addr;
        w_load_sel    = r_cmd_sel;
        w_issued_base = r_issued;
        if (r_state == ST_IDLE) begin
            w_load_we     = i_cmd_we;
            w_load_addr   = i_cmd_addr;
            w_load_sel    = i_cmd_sel;
            w_issued_base = '0;
            w_load        = w_cmd_fire && (!i_cmd_we || i_wdata_valid);
        end else if (r_state == ST_BUS) begin
            w_load = !w_burst_ok && !w_tmo_hit && (!r_stb || w_accept) &&
                     (r_issued < r_count) && (!r_wb_we || i_wdata_valid);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_sel    <= '0;
            r_cmd_sel   <= '0;
            r_next_addr <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_acked     <= '0;
            r_tmo       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_state     <= ST_BUS;
                        r_cyc       <= 1'b1;
                        r_wb_we     <= i_cmd_we;
                        r_cmd_sel   <= i_cmd_sel;
                        r_next_addr <= i_cmd_addr;
                        r_count     <= CNT_W'(i_cmd_len) + c_CNT_ONE;
                        r_issued    <= '0;
                        r_acked     <= '0;
                        r_tmo       <= '0;
                    end
                end
                ST_BUS: begin
                    r_acked <= w_acked_nxt;
                    if (w_burst_ok || w_tmo_hit) begin
                        r_state <= ST_DONE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= !w_burst_ok;
                    end else begin
                        r_tmo <= w_progress ? '0 : r_tmo + c_TMO_ONE;
                        if (w_accept) begin
                            r_stb <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_wb_we <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Overrides the stb clear above when a new word follows directly.
            if (w_load) begin
                r_stb       <= 1'b1;
                r_wb_addr   <= w_load_addr;
                r_next_addr <= w_load_addr + c_ADDR_ONE;
                r_wb_data   <= w_load_we ? i_wdata : 32'h0;
                r_wb_sel    <= w_load_sel;
                r_issued    <= w_issued_base + c_CNT_ONE;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_ack && !r_wb_we),
        .i_push_data (i_wb_data),
        .o_valid     (w_fifo_valid),
        .i_ready     (i_rdata_ready),
        .o_data      (o_rdata)
    );

    assign o_cmd_ready   = w_cmd_ready;
    assign o_wdata_ready = w_load && w_load_we;
    assign o_rdata_valid = w_fifo_valid;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_wb_cyc      = r_cyc;
    assign o_wb_stb      = r_stb;
    assign o_wb_we       = r_wb_we;
    assign o_wb_addr     = r_wb_addr;
    assign o_wb_data     = r_wb_data;
    assign o_wb_sel      = r_wb_sel;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_wb_burst_master
// Purpose : Directed self-checking bench for wb_burst_master with a small
//           pipelined WB memory slave (optional alternate-cycle stall).
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_burst_master;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [3:0]    cmd_len = '0, cmd_sel = '0;
    logic          wdata_valid = 1'b0;
    logic [31:0]   wdata = '0;
    logic          rdata_ready = 1'b0;
    logic          o_cmd_ready, o_wdata_ready, o_rdata_valid, o_done, o_err;
    logic [31:0]   o_rdata, o_wb_data;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [3:0]    o_wb_sel;
    logic          wb_stall, wb_ack;
    logic [31:0]   wb_rdata;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_burst_master #(.WB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_sel(cmd_sel),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(o_rdata),
        .o_done(o_done), .o_err(o_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
    );

    // ---------------- WB memory slave: one-cycle ack, logs every accept ----
    logic [31:0]   mem [64];
    logic [AW-1:0] acc_addr [64];
    logic [31:0]   acc_data [64];
    int            acc_n = 0;
    int            ack_n = 0;
    bit            ack_en = 1'b1, stall_mode = 1'b0, stray_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_stall <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= stray_ack;
            wb_stall <= stall_mode ? ~wb_stall : 1'b0;
            if (wb_ack && o_wb_cyc) ack_n <= ack_n + 1;
            if (o_wb_cyc && o_wb_stb && !wb_stall) begin
                if (acc_n < 64) begin
                    acc_addr[acc_n] <= o_wb_addr;
                    acc_data[acc_n] <= o_wb_data;
                end
                acc_n <= acc_n + 1;
                if (ack_en) begin
                    wb_ack <= 1'b1;
                    if (o_wb_we) begin
                        for (int b = 0; b < 4; b++)
                            if (o_wb_sel[b]) mem[o_wb_addr][8*b +: 8] <= o_wb_data[8*b +: 8];
                    end else begin
                        wb_rdata <= mem[o_wb_addr];
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking inside) ---------------
    logic [31:0] wr_words [16];
    bit          feed_abort = 1'b0;

    task automatic send_cmd(input bit we, input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [3:0] sel, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_cmd_ready) begin ok = 1'b1; n = cyc_cnt; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int idx = 0;
        for (int t = 0; t < 200 && idx < n && !feed_abort; t++) begin
            @(posedge clk); #1;
            wdata       = wr_words[idx];
            wdata_valid = gaps ? ((t % 2) == 0) : 1'b1;
            @(negedge clk);
            if (wdata_valid && o_wdata_ready) idx++;
        end
        @(posedge clk); #1;
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output bit err);
        ok  = 1'b0;
        err = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (o_done) begin ok = 1'b1; err = o_err; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err, o_rdata_valid, o_wdata_ready} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got cyc/stb/we/done/err/rv/wr=%b required 0000000",
                     {o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err, o_rdata_valid, o_wdata_ready});
        end
        tests_run++;
        if (o_wb_addr !== '0 || o_wb_data !== '0 || o_wb_sel !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr=%h data=%h sel=%h required all 0", o_wb_addr, o_wb_data, o_wb_sel);
        end
        tests_run++;
        if (o_cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b required 1", o_cmd_ready);
        end
    endtask

    task automatic test_write_burst();
        int n, base, bad;
        bit ok, err_seen;
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) wr_words[i] = 32'h11 * (i + 1);
        base = acc_n;
        bad = 0;
        err_seen = 1'b0;
        fork
            feed(4, 1'b0);
            begin
                send_cmd(1'b1, 6'h3E, 4'd3, 4'hF, n, ok);
                // k counts cycles after the handshake cycle N
                for (int k = 1; k <= 7; k++) begin
                    @(negedge clk);
                    if (o_wb_stb !== (k <= 4) || o_wb_cyc !== (k <= 5) ||
                        o_done !== (k == 6) || o_cmd_ready !== (k >= 7)) begin
                        bad++;
                        $display("FAIL wr_timing: N+%0d stb=%b cyc=%b done=%b cmd_ready=%b",
                                 k, o_wb_stb, o_wb_cyc, o_done, o_cmd_ready);
                    end
                    if (k == 6) err_seen = o_err;
                end
            end
        join
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL wr_cmd_accept: got no handshake required handshake"); end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL wr_timing_summary: %0d bad cycles required 0", bad); end
        tests_run++;
        if (err_seen !== 1'b0) begin tests_failed++; $display("FAIL wr_err: got %b required 0", err_seen); end
        tests_run++;
        if (acc_n - base != 4) begin tests_failed++; $display("FAIL wr_accepts: got %0d required 4", acc_n - base); end
        for (int i = 0; i < 4; i++) begin
            a = 6'h3E + AW'(i);
            tests_run++;
            if (acc_addr[base+i] !== a || acc_data[base+i] !== wr_words[i] || mem[a] !== wr_words[i]) begin
                tests_failed++;
                $display("FAIL wr_word%0d: addr=%h data=%h mem=%h required addr=%h data=%h",
                         i, acc_addr[base+i], acc_data[base+i], mem[a], a, wr_words[i]);
            end
        end
    endtask

    task automatic test_read_burst();
        int n, cnt;
        bit ok, err_seen;
        logic [31:0] got [4];
        logic [31:0] exp_w;
        rdata_ready = 1'b0;
        err_seen = 1'b1;
        send_cmd(1'b0, 6'h3E, 4'd3, 4'hF, n, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rd_cmd_accept: got no handshake required handshake"); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                tests_run++;
                if (o_rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_early: got %b required 0 at N+2", o_rdata_valid); end
            end
            if (k == 3) begin
                tests_run++;
                if (o_rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_valid_latency: got %b required 1 at N+3", o_rdata_valid); end
            end
            if (k == 6) begin
                tests_run++;
                if (o_done !== 1'b1) begin tests_failed++; $display("FAIL rd_done: got %b required 1 at N+6", o_done); end
                err_seen = o_err;
            end
            if (k >= 7) begin
                tests_run++;
                if (o_cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL rd_cmd_blocked: got %b required 0 at N+%0d", o_cmd_ready, k); end
            end
        end
        tests_run++;
        if (err_seen !== 1'b0) begin tests_failed++; $display("FAIL rd_err: got %b required 0", err_seen); end
        @(posedge clk); #1;
        rdata_ready = 1'b1;
        cnt = 0;
        for (int t = 0; t < 12 && cnt < 4; t++) begin
            @(negedge clk);
            if (o_rdata_valid) begin got[cnt] = o_rdata; cnt++; end
        end
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        tests_run++;
        if (cnt != 4) begin tests_failed++; $display("FAIL rd_count: got %0d words required 4", cnt); end
        for (int i = 0; i < cnt; i++) begin
            exp_w = 32'h11 * (i + 1);
            tests_run++;
            if (got[i] !== exp_w) begin tests_failed++; $display("FAIL rd_word%0d: got %h required %h", i, got[i], exp_w); end
        end
        @(negedge clk);
        tests_run++;
        if (o_rdata_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_drained: rdata_valid=%b cmd_ready=%b required 0/1", o_rdata_valid, o_cmd_ready);
        end
    endtask

    task automatic test_stall();
        int n, base, hold_bad;
        bit ok, d_ok, d_err, prev_stalled;
        logic [AW-1:0] prev_addr;
        logic [31:0]   prev_data;
        for (int i = 0; i < 8; i++) wr_words[i] = 32'hA000_0000 + i;
        base = acc_n;
        hold_bad = 0;
        d_ok = 1'b0;
        d_err = 1'b1;
        prev_stalled = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        stall_mode = 1'b1;
        fork
            feed(8, 1'b0);
            begin
                send_cmd(1'b1, 6'h10, 4'd7, 4'hF, n, ok);
                for (int t = 0; t < 60 && !d_ok; t++) begin
                    @(negedge clk);
                    if (prev_stalled && (o_wb_addr !== prev_addr || o_wb_data !== prev_data)) hold_bad++;
                    prev_stalled = o_wb_stb && wb_stall;
                    prev_addr = o_wb_addr;
                    prev_data = o_wb_data;
                    if (o_done) begin d_ok = 1'b1; d_err = o_err; end
                end
            end
        join
        stall_mode = 1'b0;
        tests_run++;
        if (!d_ok || d_err !== 1'b0) begin tests_failed++; $display("FAIL stall_done: done=%b err=%b required 1/0", d_ok, d_err); end
        tests_run++;
        if (hold_bad != 0) begin tests_failed++; $display("FAIL stall_hold: %0d changes under stall required 0", hold_bad); end
        tests_run++;
        if (acc_n - base != 8) begin tests_failed++; $display("FAIL stall_accepts: got %0d required 8", acc_n - base); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (acc_addr[base+i] !== 6'h10 + AW'(i) || acc_data[base+i] !== wr_words[i]) begin
                tests_failed++;
                $display("FAIL stall_word%0d: addr=%h data=%h required addr=%h data=%h",
                         i, acc_addr[base+i], acc_data[base+i], 6'h10 + AW'(i), wr_words[i]);
            end
        end
    endtask

    task automatic test_wdata_gaps();
        int n, base, ack_base, bad;
        bit ok, d_ok, d_err;
        for (int i = 0; i < 16; i++) wr_words[i] = 32'hC000_0000 + i;
        base = acc_n;
        ack_base = ack_n;
        fork
            feed(16, 1'b1);
            begin
                send_cmd(1'b1, 6'h20, 4'd15, 4'hF, n, ok);
                wait_done(200, d_ok, d_err);
            end
        join
        tests_run++;
        if (!d_ok || d_err !== 1'b0) begin tests_failed++; $display("FAIL gaps_done: done=%b err=%b required 1/0", d_ok, d_err); end
        tests_run++;
        if (ack_n - ack_base != 16 || acc_n - base != 16) begin
            tests_failed++;
            $display("FAIL gaps_counts: acks=%0d accepts=%0d required 16/16", ack_n - ack_base, acc_n - base);
        end
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (acc_data[base+i] !== wr_words[i] || acc_addr[base+i] !== 6'h20 + AW'(i)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL gaps_words: %0d wrong words required 0", bad); end
    endtask

    task automatic test_timeout();
        int n, bad;
        bit ok, err_seen;
        ack_en = 1'b0;
        bad = 0;
        err_seen = 1'b0;
        send_cmd(1'b0, 6'h00, 4'd1, 4'hF, n, ok);
        // accepts at N+1, N+2; ten idle cycles N+3..N+12; done at N+13
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (o_wb_cyc !== (k <= 12) || o_wb_stb !== (k <= 2) || o_done !== (k == 13)) begin
                bad++;
                $display("FAIL tmo_timing: N+%0d cyc=%b stb=%b done=%b", k, o_wb_cyc, o_wb_stb, o_done);
            end
            if (k == 13) err_seen = o_err;
        end
        tests_run++;
        if (!ok || bad != 0) begin tests_failed++; $display("FAIL tmo_timing_summary: %0d bad cycles, hs=%b required 0/1", bad, ok); end
        tests_run++;
        if (err_seen !== 1'b1) begin tests_failed++; $display("FAIL tmo_err: got %b required 1", err_seen); end
        ack_en = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (o_rdata_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_late_ack: rdata_valid=%b cmd_ready=%b done=%b required 0/1/0",
                     o_rdata_valid, o_cmd_ready, o_done);
        end
    endtask

    task automatic test_async_reset();
        int n, base;
        bit ok, reached;
        for (int i = 0; i < 16; i++) wr_words[i] = 32'hD000_0000 + i;
        base = acc_n;
        reached = 1'b0;
        fork
            feed(16, 1'b0);
            begin
                send_cmd(1'b1, 6'h30, 4'd15, 4'hF, n, ok);
                for (int t = 0; t < 40 && !reached; t++) begin
                    @(negedge clk);
                    if (acc_n - base >= 5) reached = 1'b1;
                end
                rst_n = 1'b0;
                feed_abort = 1'b1;
                #1;
                tests_run++;
                if (!reached) begin tests_failed++; $display("FAIL arst_reach: got %0d accepts required 5", acc_n - base); end
                tests_run++;
                if ({o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err, o_rdata_valid, o_wdata_ready} !== 7'b0 ||
                    o_wb_addr !== '0 || o_wb_data !== '0 || o_wb_sel !== '0) begin
                    tests_failed++;
                    $display("FAIL arst_outputs: cyc/stb/we/done/err/rv/wr=%b addr=%h data=%h sel=%h required all 0",
                             {o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err, o_rdata_valid, o_wdata_ready},
                             o_wb_addr, o_wb_data, o_wb_sel);
                end
                @(posedge clk);
                @(posedge clk); #3;
                rst_n = 1'b1;
                @(negedge clk);
                tests_run++;
                if (o_cmd_ready !== 1'b1 || o_wb_cyc !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL arst_release: cmd_ready=%b cyc=%b required 1/0", o_cmd_ready, o_wb_cyc);
                end
            end
        join
        feed_abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_stall();
        test_wdata_gaps();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
